window3x3_gen: RTL and testbench

- Converts a raster-order pixel stream into 3x3 neighbourhood windows for the median filter's compare-swap network.
- Uses two line buffers plus a 3x3 register array.
- Emits a window only when all nine pixels lie inside the frame. There is no border padding, so each frame yields (IMG_W-2)*(IMG_H-2) windows.
- It is the upstream producer of the data the sort network consumes.

---
 rtl/window3x3_gen.sv | 125 ++++++++++++
 tb/tb_window3x3_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows for the median sort network.
// Two line buffers feed the right-hand column of a 3x3 shift array; only fully in-frame windows flag valid.
module window3x3_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] w00_o,
  output logic [DATA_W-1:0] w01_o,
  output logic [DATA_W-1:0] w02_o,
  output logic [DATA_W-1:0] w10_o,
  output logic [DATA_W-1:0] w11_o,
  output logic [DATA_W-1:0] w12_o,
  output logic [DATA_W-1:0] w20_o,
  output logic [DATA_W-1:0] w21_o,
  output logic [DATA_W-1:0] w22_o,
  output logic              valid_o,
  output logic              done_o
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            col_last, row_last;

  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  logic [DATA_W-1:0] win_q [3][3];

  logic valid_q, valid_d;
  logic done_q, done_d;

  assign col_last = (col_q == ColW'(IMG_W - 1));
  assign row_last = (row_q == RowW'(IMG_H - 1));

  // Raster position of the pixel presented this cycle.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers are addressed by column, so the slot read back is the same column one/two lines up.
  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];

  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb2_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_rd;
      win_q[1][2] <= lb1_rd;
      win_q[2][2] <= data_i;
    end
  end

  // Windows touching rows 0-1 or cols 0-1 would mix in stale or wrapped pixels.
  always_comb begin
    valid_d = valid_i && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    done_d  = valid_i && row_last && col_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign w00_o   = win_q[0][0];
  assign w01_o   = win_q[0][1];
  assign w02_o   = win_q[0][2];
  assign w10_o   = win_q[1][0];
  assign w11_o   = win_q[1][1];
  assign w12_o   = win_q[1][2];
  assign w20_o   = win_q[2][0];
  assign w21_o   = win_q[2][1];
  assign w22_o   = win_q[2][2];
  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Randomized bench for window3x3_gen: every output is predicted each cycle from the
// history of pixels accepted since the last reset.
module tb_window3x3_gen;

  localparam int W = 5;
  localparam int H = 4;
  localparam logic [71:0] FirstWin = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
  localparam logic [71:0] LastWin  = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
  localparam logic [71:0] F2Win    = {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107,
                                      8'd110, 8'd111, 8'd112};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [7:0] data_i;
  logic [7:0] w00_o, w01_o, w02_o, w10_o, w11_o, w12_o, w20_o, w21_o, w22_o;
  logic       valid_o, done_o;
  logic [7:0] wv [9];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hist[$];
  logic [71:0] win_log[$];
  logic [71:0] ref_log[$];
  logic [71:0] done_win;
  int          n_valid, n_done;

  always #5 clk = ~clk;

  window3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .data_i  (data_i),
    .w00_o   (w00_o),
    .w01_o   (w01_o),
    .w02_o   (w02_o),
    .w10_o   (w10_o),
    .w11_o   (w11_o),
    .w12_o   (w12_o),
    .w20_o   (w20_o),
    .w21_o   (w21_o),
    .w22_o   (w22_o),
    .valid_o (valid_o),
    .done_o  (done_o)
  );

  always_comb begin
    wv[0] = w00_o; wv[1] = w01_o; wv[2] = w02_o;
    wv[3] = w10_o; wv[4] = w11_o; wv[5] = w12_o;
    wv[6] = w20_o; wv[7] = w21_o; wv[8] = w22_o;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixel k is the latest accepted; window cell (i,j) holds the pixel (2-i) lines and
  // (2-j) pixels back. Cells whose column slot was never loaded since reset read 0;
  // cells sourced from unwritten line-buffer slots are unknown and skipped.
  task automatic check_outputs(input bit acc);
    int k;
    int base;
    int idx;
    bit ev;
    bit ed;
    k  = hist.size() - 1;
    ev = 1'b0;
    ed = 1'b0;
    if (acc && k >= 0) begin
      ev = ((k / W) % H >= 2) && (k % W >= 2);
      ed = ((k / W) % H == H - 1) && (k % W == W - 1);
    end
    chk("valid_o", 72'(valid_o), 72'(ev));
    chk("done_o", 72'(done_o), 72'(ed));
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        base = k - (2 - j);
        if (base < 0) begin
          chk($sformatf("w%0d%0d_o", i, j), 72'(wv[i*3+j]), 72'(0));
        end else begin
          idx = base - (2 - i) * W;
          if (idx >= 0) chk($sformatf("w%0d%0d_o", i, j), 72'(wv[i*3+j]), 72'(hist[idx]));
        end
      end
    end
    if (valid_o) begin
      win_log.push_back({wv[0], wv[1], wv[2], wv[3], wv[4], wv[5], wv[6], wv[7], wv[8]});
      n_valid++;
    end
    if (done_o) begin
      done_win = {wv[0], wv[1], wv[2], wv[3], wv[4], wv[5], wv[6], wv[7], wv[8]};
      n_done++;
    end
  endtask

  task automatic cycle(input bit v, input int d);
    @(negedge clk);
    valid_i = v;
    data_i  = 8'(d);
    @(posedge clk);
    #1;
    if (v) hist.push_back(d);
    check_outputs(v);
  endtask

  task automatic send_frame(input int base, input bit stall);
    for (int idx = 0; idx < W * H; idx++) begin
      if (stall && idx > 0) begin
        repeat ($urandom_range(1, 3)) cycle(1'b0, int'($urandom_range(0, 255)));
      end
      cycle(1'b1, base + idx);
    end
    cycle(1'b0, 0);
  endtask

  task automatic clear_stats();
    n_valid = 0;
    n_done  = 0;
    win_log.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    clear_stats();

    // Reset held: random inputs must not disturb anything.
    repeat (4) begin
      @(negedge clk);
      valid_i = 1'($urandom);
      data_i  = 8'($urandom);
      @(posedge clk);
      #1;
      check_outputs(1'b0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b0;

    // Continuous frame: first window, last window, done.
    clear_stats();
    send_frame(0, 1'b0);
    chk("f1_valid_count", 72'(n_valid), 72'(6));
    chk("f1_done_count", 72'(n_done), 72'(1));
    chk("f1_first_win", win_log[0], FirstWin);
    chk("f1_last_win", win_log[5], LastWin);
    chk("f1_done_win", done_win, LastWin);
    ref_log = win_log;

    // Same frame with random stalls between pixels.
    clear_stats();
    send_frame(0, 1'b1);
    chk("stall_valid_count", 72'(n_valid), 72'(6));
    chk("stall_done_count", 72'(n_done), 72'(1));
    for (int i = 0; i < 6; i++) chk($sformatf("stall_win%0d", i), win_log[i], ref_log[i]);

    // Back-to-back frames, no idle cycle between them.
    clear_stats();
    for (int idx = 0; idx < W * H; idx++) cycle(1'b1, idx);
    for (int idx = 0; idx < W * H; idx++) cycle(1'b1, 100 + idx);
    cycle(1'b0, 0);
    chk("b2b_valid_count", 72'(n_valid), 72'(12));
    chk("b2b_done_count", 72'(n_done), 72'(2));
    chk("b2b_f2_first_win", win_log[6], F2Win);

    // Mid-frame reset after pixel 13, then restart.
    clear_stats();
    for (int idx = 0; idx <= 13; idx++) cycle(1'b1, idx);
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    check_outputs(1'b0);
    @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    clear_stats();
    send_frame(0, 1'b0);
    chk("rst_valid_count", 72'(n_valid), 72'(6));
    chk("rst_done_count", 72'(n_done), 72'(1));
    for (int i = 0; i < 6; i++) chk($sformatf("rst_win%0d", i), win_log[i], ref_log[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
